// File: rtl/payload_ingress_writer_if.sv
// rtl/payload_ingress_writer_if.sv - input stream, payload write bus and descriptor signals of the ingress writer
//
// Groups every handshake/bus signal of payload_ingress_writer.
//   in_*   : packet word stream (valid/ready, sop/eop, ttl, last_bytes)
//   pw_*   : payload write bus, driven by the writer (pw_ready/pw_address come back)
//   desc_* : one descriptor per stored packet (valid/ready)
//   drop_count : saturating dropped-packet counter
// modport master : the writer itself (it masters the payload write bus)
// modport slave  : the surroundings (stream source, payload store, descriptor sink)
interface payload_ingress_writer_if #(
    parameter int DATA_W  = 32,
    parameter int BYTES_W = 2,
    parameter int TTL_W   = 8,
    parameter int BC_W    = 12,
    parameter int ADDR_W  = 10
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic                in_sop;
    logic                in_eop;
    logic [TTL_W-1:0]    in_ttl;
    logic [BYTES_W-1:0]  in_last_bytes;

    logic                pw_ready;
    logic                pw_write;
    logic                pw_isLast;
    logic [DATA_W-1:0]   pw_data;
    logic [TTL_W-1:0]    pw_ttl;
    logic [BC_W-1:0]     pw_byteCount;
    logic [ADDR_W-1:0]   pw_address;

    logic                desc_valid;
    logic                desc_ready;
    logic [ADDR_W-1:0]   desc_address;
    logic [TTL_W-1:0]    desc_ttl;
    logic [BC_W-1:0]     desc_byteCount;

    logic [15:0]         drop_count;

    modport master (
        input  in_valid, in_data, in_sop, in_eop, in_ttl, in_last_bytes,
        output in_ready,
        input  pw_ready, pw_address,
        output pw_write, pw_isLast, pw_data, pw_ttl, pw_byteCount,
        input  desc_ready,
        output desc_valid, desc_address, desc_ttl, desc_byteCount,
        output drop_count
    );

    modport slave (
        output in_valid, in_data, in_sop, in_eop, in_ttl, in_last_bytes,
        input  in_ready,
        output pw_ready, pw_address,
        input  pw_write, pw_isLast, pw_data, pw_ttl, pw_byteCount,
        output desc_ready,
        input  desc_valid, desc_address, desc_ttl, desc_byteCount,
        input  drop_count
    );
endinterface

// File: rtl/payload_ingress_writer.sv
// rtl/payload_ingress_writer.sv - store-and-forward packet buffer feeding the payload write bus
//
// Buffers one whole packet from the word stream, computes its byte count and
// decremented TTL, drains it onto the payload write bus one word per pw_ready
// cycle, then presents a descriptor {address, ttl, byteCount}. Malformed
// (sop before eop, oversize) and expired (ttl==0) packets are dropped and counted.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : payload_ingress_writer_if.master (stream in, payload bus, descriptor, drop_count)
module payload_ingress_writer #(
    parameter int DATA_W  = 32,
    parameter int BYTES_W = 2,
    parameter int TTL_W   = 8,
    parameter int BC_W    = 12,
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 64
) (
    input  logic clk,
    input  logic reset,
    payload_ingress_writer_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int BPW   = DATA_W / 8;

    // The largest packet byte count must be representable in pw_byteCount.
    generate
        if (DEPTH * BPW >= (1 << BC_W)) begin : g_bc_too_narrow
            $error("BC_W too narrow for DEPTH words");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, RECV, DROP, WRITE, DESC} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    wcnt, wcnt_n;
    logic [IDX_W-1:0]    rd, rd_n;
    logic [TTL_W-1:0]    ttl_q, ttl_n;
    logic [TTL_W-1:0]    fwd_ttl, fwd_ttl_n;
    logic [BC_W-1:0]     bc_q, bc_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [15:0]         drop_q;
    logic [1:0]          drop_inc;
    logic                mem_we;
    logic [IDX_W-1:0]    mem_idx;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                in_ready_c;
    logic                accept;
    logic                is_start;
    logic                is_cont;
    logic                is_end;
    logic [TTL_W-1:0]    pkt_ttl;
    logic [BC_W-1:0]     lb_eff;
    logic [BC_W-1:0]     bc_calc;
    logic [IDX_W-1:0]    last_idx;
    logic [16:0]         drop_sum;

    assign in_ready_c = !reset && (state == IDLE || state == RECV || state == DROP);
    assign accept     = bus.in_valid && in_ready_c;

    // A sop beat always opens a new packet, even in the middle of another one.
    assign is_start = accept && bus.in_sop && (state == IDLE || state == RECV);
    assign is_cont  = accept && !bus.in_sop && state == RECV && wcnt != CNT_W'(DEPTH);
    assign is_end   = (is_start || is_cont) && bus.in_eop;

    // TTL of the packet being closed: a sop+eop beat carries its own.
    assign pkt_ttl  = is_start ? bus.in_ttl : ttl_q;
    assign lb_eff   = (bus.in_last_bytes == '0) ? BC_W'(BPW) : BC_W'(bus.in_last_bytes);
    // Words before the eop beat times bytes per word, plus the eop beat's bytes.
    assign bc_calc  = (is_start ? '0 : BC_W'(wcnt)) * BC_W'(BPW) + lb_eff;
    assign last_idx = IDX_W'(wcnt - CNT_W'(1));
    assign drop_sum = {1'b0, drop_q} + 17'(drop_inc);

    always_comb begin
        state_n   = state;
        wcnt_n    = wcnt;
        rd_n      = rd;
        ttl_n     = ttl_q;
        fwd_ttl_n = fwd_ttl;
        bc_n      = bc_q;
        addr_n    = addr_q;
        drop_inc  = 2'd0;
        mem_we    = 1'b0;
        mem_idx   = wcnt[IDX_W-1:0];
        bus.pw_write = 1'b0;
        case (state)
            IDLE, RECV: begin
                if (is_start) begin
                    // An unfinished packet in RECV is abandoned.
                    if (state == RECV) drop_inc = 2'd1;
                    mem_we  = 1'b1;
                    mem_idx = '0;
                    wcnt_n  = CNT_W'(1);
                    ttl_n   = bus.in_ttl;
                    state_n = RECV;
                end else if (is_cont) begin
                    mem_we = 1'b1;
                    wcnt_n = wcnt + CNT_W'(1);
                end else if (accept && state == RECV) begin
                    // Buffer already full: oversize packet. If this beat ends
                    // it there is nothing left to discard.
                    drop_inc = 2'd1;
                    state_n  = bus.in_eop ? IDLE : DROP;
                end
                if (is_end) begin
                    if (pkt_ttl == '0) begin
                        drop_inc = drop_inc + 2'd1;
                        state_n  = IDLE;
                    end else begin
                        bc_n      = bc_calc;
                        fwd_ttl_n = pkt_ttl - TTL_W'(1);
                        rd_n      = '0;
                        state_n   = WRITE;
                    end
                end
            end
            DROP: begin
                if (accept && bus.in_eop) state_n = IDLE;
            end
            WRITE: begin
                bus.pw_write = bus.pw_ready;
                if (bus.pw_ready) begin
                    if (rd == '0) addr_n = bus.pw_address;
                    if (rd == last_idx) state_n = DESC;
                    else                rd_n    = rd + IDX_W'(1);
                end
            end
            DESC: begin
                if (bus.desc_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            wcnt    <= '0;
            rd      <= '0;
            ttl_q   <= '0;
            fwd_ttl <= '0;
            bc_q    <= '0;
            addr_q  <= '0;
            drop_q  <= '0;
        end else begin
            state   <= state_n;
            wcnt    <= wcnt_n;
            rd      <= rd_n;
            ttl_q   <= ttl_n;
            fwd_ttl <= fwd_ttl_n;
            bc_q    <= bc_n;
            addr_q  <= addr_n;
            drop_q  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= bus.in_data;
    end

    assign bus.in_ready       = in_ready_c;
    // Data and isLast follow rd, so they hold through pw_ready stalls.
    assign bus.pw_data        = (state == WRITE) ? mem[rd] : '0;
    assign bus.pw_isLast      = (state == WRITE) && (rd == last_idx);
    assign bus.pw_ttl         = fwd_ttl;
    assign bus.pw_byteCount   = bc_q;
    assign bus.desc_valid     = (state == DESC);
    assign bus.desc_address   = addr_q;
    assign bus.desc_ttl       = fwd_ttl;
    assign bus.desc_byteCount = bc_q;
    assign bus.drop_count     = drop_q;
endmodule

// File: tb/tb_payload_ingress_writer.sv
// tb/tb_payload_ingress_writer.sv - directed self-checking bench for payload_ingress_writer
module tb_payload_ingress_writer;
    localparam int DEPTH = 64;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;
    logic [31:0] exp_data [0:DEPTH+3];

    payload_ingress_writer_if #(.DATA_W(32), .BYTES_W(2), .TTL_W(8), .BC_W(12), .ADDR_W(10)) bus ();

    payload_ingress_writer #(
        .DATA_W(32), .BYTES_W(2), .TTL_W(8), .BC_W(12), .ADDR_W(10), .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                             input logic [7:0] t, input logic [1:0] lb);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_sop = sop;
        bus.in_eop = eop;
        bus.in_ttl = t;
        bus.in_last_bytes = lb;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 100) check_eq("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_sop = 1'b0;
        bus.in_eop = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [7:0] t, input logic [1:0] lb);
        for (int i = 0; i < n; i++)
            send_beat(exp_data[i], i == 0, i == n - 1, t, lb);
    endtask

    task automatic drain(input int n, input logic [15:0] pat, input logic [9:0] addr0,
                         input logic [7:0] ettl, input logic [11:0] ebc, output int cycles);
        int s;
        int c;
        s = 0;
        c = 0;
        while (s < n && c < 200) begin
            bus.pw_ready = (c < 16) ? pat[c] : 1'b1;
            bus.pw_address = addr0 + 10'(s * 16);
            #1;
            check_eq("in_ready_in_write", 32'(bus.in_ready), 32'd0);
            check_eq("desc_valid_in_write", 32'(bus.desc_valid), 32'd0);
            check_eq("pw_write", 32'(bus.pw_write), 32'(bus.pw_ready));
            check_eq("pw_data", bus.pw_data, exp_data[s]);
            check_eq("pw_isLast", 32'(bus.pw_isLast), 32'(s == n - 1));
            check_eq("pw_ttl", 32'(bus.pw_ttl), 32'(ettl));
            check_eq("pw_byteCount", 32'(bus.pw_byteCount), 32'(ebc));
            if (bus.pw_write) s++;
            tick();
            c++;
        end
        bus.pw_ready = 1'b0;
        check_eq("strobe_count", 32'(s), 32'(n));
        cycles = c;
    endtask

    task automatic take_desc(input int hold, input logic [9:0] eaddr,
                             input logic [7:0] ettl, input logic [11:0] ebc);
        bus.desc_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            #1;
            check_eq("desc_valid_hold", 32'(bus.desc_valid), 32'd1);
            check_eq("desc_address_hold", 32'(bus.desc_address), 32'(eaddr));
            check_eq("desc_ttl_hold", 32'(bus.desc_ttl), 32'(ettl));
            check_eq("desc_byteCount_hold", 32'(bus.desc_byteCount), 32'(ebc));
            check_eq("in_ready_in_desc", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.desc_ready = 1'b1;
        #1;
        check_eq("desc_valid", 32'(bus.desc_valid), 32'd1);
        check_eq("desc_address", 32'(bus.desc_address), 32'(eaddr));
        check_eq("desc_ttl", 32'(bus.desc_ttl), 32'(ettl));
        check_eq("desc_byteCount", 32'(bus.desc_byteCount), 32'(ebc));
        tick();
        bus.desc_ready = 1'b0;
        #1;
        check_eq("desc_valid_after", 32'(bus.desc_valid), 32'd0);
        check_eq("in_ready_after_desc", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic idle_quiet(input int n, input int edrop);
        bus.pw_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check_eq("quiet_pw_write", 32'(bus.pw_write), 32'd0);
            check_eq("quiet_desc_valid", 32'(bus.desc_valid), 32'd0);
            check_eq("quiet_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        bus.pw_ready = 1'b0;
        check_eq("drop_count", 32'(bus.drop_count), 32'(edrop));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_sop = 1'b0;
        bus.in_eop = 1'b0;
        bus.in_ttl = '0;
        bus.in_last_bytes = '0;
        bus.pw_ready = 1'b0;
        bus.pw_address = '0;
        bus.desc_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        bus.pw_ready = 1'b1;
        #1;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_pw_write", 32'(bus.pw_write), 32'd0);
        check_eq("rst_pw_isLast", 32'(bus.pw_isLast), 32'd0);
        check_eq("rst_pw_data", bus.pw_data, 32'd0);
        check_eq("rst_pw_ttl", 32'(bus.pw_ttl), 32'd0);
        check_eq("rst_desc_valid", 32'(bus.desc_valid), 32'd0);
        check_eq("rst_desc_address", 32'(bus.desc_address), 32'd0);
        check_eq("rst_drop_count", 32'(bus.drop_count), 32'd0);
        bus.pw_ready = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("idle_in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        // Stray beat without sop is ignored
        send_beat(32'hDEAD0000, 1'b0, 1'b1, 8'd3, 2'd1);
        idle_quiet(2, 0);

        // 3 words, ttl 5, last_bytes 2 -> byteCount 10, ttl 4, address 0x040
        exp_data[0] = 32'hAAAA0001;
        exp_data[1] = 32'hBBBB0002;
        exp_data[2] = 32'hCCCC0003;
        send_pkt(3, 8'd5, 2'd2);
        drain(3, 16'hFFFF, 10'h040, 8'd4, 12'd10, cyc);
        check_eq("latency_3w", 32'(cyc), 32'd3);
        take_desc(0, 10'h040, 8'd4, 12'd10);

        // Single beat, last_bytes 0 (=4), ttl 1 -> byteCount 4, ttl 0
        exp_data[0] = 32'h11223344;
        send_pkt(1, 8'd1, 2'd0);
        drain(1, 16'hFFFF, 10'h100, 8'd0, 12'd4, cyc);
        check_eq("latency_1w", 32'(cyc), 32'd1);
        take_desc(1, 10'h100, 8'd0, 12'd4);

        // Expired packet is dropped, the next one passes
        exp_data[0] = 32'h0BAD0001;
        exp_data[1] = 32'h0BAD0002;
        send_pkt(2, 8'd0, 2'd1);
        idle_quiet(3, 1);
        exp_data[0] = 32'h22220001;
        exp_data[1] = 32'h22220002;
        send_pkt(2, 8'd9, 2'd3);
        drain(2, 16'hFFFF, 10'h0A0, 8'd8, 12'd7, cyc);
        take_desc(2, 10'h0A0, 8'd8, 12'd7);

        // Oversize packet (DEPTH+3 words) is dropped and drained through eop
        for (int i = 0; i < DEPTH + 3; i++) exp_data[i] = 32'h30000000 + 32'(i);
        send_pkt(DEPTH + 3, 8'd3, 2'd2);
        idle_quiet(3, 2);

        // Exactly DEPTH words fits: byteCount 256
        for (int i = 0; i < DEPTH; i++) exp_data[i] = 32'h40000000 + 32'(i * 3);
        send_pkt(DEPTH, 8'd2, 2'd0);
        drain(DEPTH, 16'hFFFF, 10'h3F0, 8'd1, 12'd256, cyc);
        take_desc(0, 10'h3F0, 8'd1, 12'd256);

        // sop before eop drops the partial packet and restarts on the new sop
        send_beat(32'h5555AAAA, 1'b1, 1'b0, 8'd4, 2'd0);
        exp_data[0] = 32'h66660001;
        exp_data[1] = 32'h66660002;
        send_beat(exp_data[0], 1'b1, 1'b0, 8'd6, 2'd0);
        send_beat(exp_data[1], 1'b0, 1'b1, 8'd0, 2'd3);
        check_eq("drop_count_partial", 32'(bus.drop_count), 32'd3);
        drain(2, 16'hFFFF, 10'h077, 8'd5, 12'd7, cyc);
        take_desc(0, 10'h077, 8'd5, 12'd7);

        // pw_ready 1,0,0,1,1 stalls; descriptor held 4 cycles
        exp_data[0] = 32'h77770001;
        exp_data[1] = 32'h77770002;
        exp_data[2] = 32'h77770003;
        send_pkt(3, 8'd7, 2'd1);
        drain(3, 16'b1111_1111_1111_1001, 10'h200, 8'd6, 12'd9, cyc);
        check_eq("stall_cycles", 32'(cyc), 32'd5);
        take_desc(4, 10'h200, 8'd6, 12'd9);

        // Reset during WRITE after 1 of 4 words
        for (int i = 0; i < 4; i++) exp_data[i] = 32'h88880000 + 32'(i);
        send_pkt(4, 8'd3, 2'd0);
        bus.pw_ready = 1'b1;
        bus.pw_address = 10'h123;
        #1;
        check_eq("pre_reset_strobe", 32'(bus.pw_write), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        check_eq("in_ready_during_reset", 32'(bus.in_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_eq("post_reset_pw_write", 32'(bus.pw_write), 32'd0);
        check_eq("post_reset_desc_valid", 32'(bus.desc_valid), 32'd0);
        check_eq("post_reset_drop_count", 32'(bus.drop_count), 32'd0);
        check_eq("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("post_reset_desc_address", 32'(bus.desc_address), 32'd0);
        bus.pw_ready = 1'b0;
        tick();

        // Normal operation after reset
        exp_data[0] = 32'h99990001;
        send_pkt(1, 8'd9, 2'd3);
        drain(1, 16'hFFFF, 10'h055, 8'd8, 12'd3, cyc);
        take_desc(1, 10'h055, 8'd8, 12'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/payload_ingress_writer.md
Name: payload_ingress_writer

Overview:
- Store-and-forward stage directly upstream of the payload write bus; acts as its Master.
- Accepts a word stream of packets with valid/ready, buffers one whole packet, and computes its total byte count and decremented TTL.
- Drains the packet onto the payload write bus one word per cycle and captures the start address returned by the payload store.
- Emits one descriptor (start address, ttl, byteCount) per stored packet; drops malformed or expired packets.

Parameters:
DATA_W, 32, payload word width (Data_t)
BYTES_W, 2, in_last_bytes width; bytes per word = DATA_W/8 = 4
TTL_W, 8, Ttl_t width
BC_W, 12, ByteCount_t width
ADDR_W, 10, Address_t width
DEPTH, 64, packet buffer depth in words (max packet = DEPTH words)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  DATA_W  payload word
in_sop  in  1  first beat of packet
in_eop  in  1  last beat of packet
in_ttl  in  TTL_W  packet TTL, sampled on the sop beat
in_last_bytes  in  BYTES_W  valid bytes in the eop beat (0 encodes 4)
pw_ready  in  1  payload store can take a word this cycle
pw_write  out  1  word strobe accompanying the bus fields
pw_isLast  out  1  payload bus isLast
pw_data  out  DATA_W  payload bus data
pw_ttl  out  TTL_W  payload bus ttl
pw_byteCount  out  BC_W  payload bus byteCount (packet total, constant across beats)
pw_address  in  ADDR_W  payload bus address; valid in the same cycle as pw_write
desc_valid  out  1  descriptor valid
desc_ready  in  1  descriptor consumer ready
desc_address  out  ADDR_W  address captured on the first write beat
desc_ttl  out  TTL_W  forwarded TTL (in_ttl-1)
desc_byteCount  out  BC_W  packet byte count
drop_count  out  16  saturating count of dropped packets

Behaviour:
- Reset: state=IDLE; in_ready=0 during reset; pw_write=0; pw_isLast=0; pw_data/pw_ttl/pw_byteCount=0; desc_valid=0; desc_* fields=0; drop_count=0; word counters=0. Reset asserted mid-operation discards any buffered packet and any pending descriptor.
- FSM states: IDLE, RECV, DROP, WRITE, DESC.
- IDLE: in_ready=1.
  - Beat without sop: discarded, not counted.
  - sop beat: store the word at buffer[0]; latch in_ttl; wcnt=1.
  - If eop is also set: go to WRITE (or DROP handling per TTL rule below). Otherwise go to RECV.
- RECV: in_ready=1; each accepted beat is written to buffer[wcnt] and increments wcnt.
  - eop: go to WRITE.
  - sop before eop: drop the partial packet (drop_count+1) and treat the sop beat as the start of a new packet (same cycle).
  - Beat that would make wcnt > DEPTH: go to DROP and increment drop_count.
- DROP: in_ready=1; discard beats until an eop beat is accepted, then go to IDLE.
- TTL rule: a packet whose latched ttl == 0 is dropped at eop (drop_count+1, return to IDLE, nothing written).
- byteCount = (wcnt-1)*4 + (in_last_bytes==0 ? 4 : in_last_bytes), computed at eop. Range 1..DEPTH*4, must fit BC_W; the compile-time check is DEPTH*4 < 2^BC_W.
- WRITE: in_ready=0.
  - Each cycle with pw_ready=1: pw_write=1 and pw_data=buffer[rd]; rd increments.
  - pw_ttl = ttl-1 and pw_byteCount are held constant for the whole packet.
  - pw_isLast=1 only on the word with rd == wcnt-1.
  - pw_ready=0 stalls: pw_write=0 and all outputs are held.
  - On the first strobe, capture pw_address into desc_address. After the last strobe go to DESC.
  - A one-word packet has isLast=1 on its single strobe.
- DESC: desc_valid=1 with fields stable until desc_ready; on the handshake go to IDLE.
  - desc_valid is asserted no earlier than the cycle after the last strobe.
  - in_ready=0 until the handshake completes.
- Latency: first pw_write occurs in the cycle after the eop beat is accepted, if pw_ready=1.
- drop_count saturates at 0xFFFF.
- Throughput: one packet in flight. in_ready is low during WRITE and DESC.

Test Plan:
- 3-word packet, sop ttl=5, words A,B,C, eop last_bytes=2, pw_ready=1, pw_address=0x040 on first strobe -> pw_write for 3 cycles, isLast only on C, pw_ttl=4, pw_byteCount=10; descriptor {0x040,4,10}.
- Single-beat packet with sop=eop, last_bytes=0, ttl=1 -> one strobe with isLast=1, byteCount=4, ttl=0; descriptor emitted.
- ttl=0 packet of 2 words -> no pw_write, no descriptor, drop_count=1; the next valid packet passes normally.
- DEPTH+1-word packet -> drop_count increments; remaining beats accepted and discarded through eop; no writes.
- pw_ready toggled 1,0,0,1,1 on a 3-word packet -> exactly 3 strobes, outputs held during stalls, address captured from the first strobe only; desc_ready held low 4 cycles -> desc fields stable, in_ready=0 throughout.
- Reset asserted during WRITE after 1 of 4 words -> next cycle pw_write=0, desc_valid=0, drop_count=0, state IDLE.
